ccd_readout_sequencer: RTL and testbench
========================================

Name: ccd_readout_sequencer

Overview:
- Frame-level controller for the CCD clocking datapath.
- On a start request it runs integration, then for each row issues one parallel transfer (phi_p) followed by a horizontal shift of N_COLS pixels (phi_l1/phi_l2 with reset gate phi_r).
- Emits a one-cycle ADC sample strobe per pixel plus row/column indices.
- Sits between the system control FSM and the CCD clock drivers/ADC capture.

Parameters:
- N_ROWS, 4, rows read per frame (>=1)
- N_COLS, 8, pixels shifted per row (>=1)
- HALF, 4, cycles per half pixel period; pixel period = 2*HALF (>=2)
- P_WIDTH, 4, phi_p high time in cycles (>=1)
- RST_W, 2, phi_r high cycles at pixel start (1..HALF-1)

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame request, sampled each rising edge
- abort  in  1  synchronous abort, highest priority after reset
- integ_cycles  in  16  integration length in cycles; 0 treated as 1
- busy  out  1  high from start acceptance until frame end or abort
- done  out  1  one-cycle pulse after last pixel of last row
- phi_p  out  1  parallel (vertical) transfer clock
- phi_l1  out  1  horizontal clock phase 1
- phi_l2  out  1  horizontal clock phase 2
- phi_r  out  1  output-node reset gate
- sample  out  1  one-cycle ADC capture strobe, one per pixel
- row_idx  out  clog2(N_ROWS) (min 1)  current row
- col_idx  out  clog2(N_COLS) (min 1)  current pixel within row

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, phi_p=0, phi_l1=0, phi_l2=1, phi_r=0, sample=0, row_idx=0, col_idx=0, all counters 0.
- All outputs are registered Moore outputs that update on the same edge as state/counters. No combinational input-to-output paths.
- States: IDLE, INTEG, PXFER, HSHIFT, DONE.
- IDLE:
  - Clocks at idle levels as in reset.
  - Edge with start=1 and abort=0: latch integ_len = max(integ_cycles,1); busy=1; enter INTEG.
- INTEG:
  - Clocks idle; a cycle counter counts integ_len cycles.
  - On the last cycle, move to PXFER with row_idx=0.
- PXFER:
  - phi_p=1 for exactly P_WIDTH cycles; phi_l1=0, phi_l2=1, phi_r=0 held.
  - Then enter HSHIFT with col_idx=0, phase=0.
- HSHIFT: phase counter ph runs 0..2*HALF-1 per pixel.
  - phi_l2=1, phi_l1=0 when ph<HALF; phi_l1=1, phi_l2=0 otherwise.
  - phi_r=1 when ph<RST_W, else 0.
  - sample=1 when ph==2*HALF-1.
  - At ph wrap: col_idx increments.
  - After pixel N_COLS-1 completes:
    - if row_idx==N_ROWS-1, enter DONE;
    - otherwise row_idx increments and the FSM returns to PXFER.
- DONE: done=1 for one cycle; busy=0 on the same edge; clocks idle; next state IDLE.
- Frame length: busy is high for exactly integ_len + N_ROWS*(P_WIDTH + 2*HALF*N_COLS) cycles. done follows in the next cycle.
- start while busy or in DONE is ignored. No queuing.
- abort=1 in any non-IDLE state: next edge goes to IDLE with reset output values. No done pulse. Counters cleared. abort in IDLE is ignored, and abort wins over a simultaneous start.
- Asynchronous reset mid-frame: outputs take reset values immediately. No done pulse.
- Invariants:
  - phi_p is never high together with phi_l1, phi_r or sample.
  - phi_l1 and phi_l2 are never both 1.
  - phi_l1 and phi_l2 are never both 0 outside reset.
- Counter widths are sized for the parameters. integ counter is 16 bits with no wrap. Indices never exceed N_ROWS-1 / N_COLS-1.

Test Plan:
- Defaults, integ_cycles=10, start pulse -> busy high 282 cycles, done pulse on cycle 283, 4 phi_p pulses each 4 cycles wide, exactly 32 sample pulses.
- Per-pixel waveform check in HSHIFT -> phi_l2 high ph 0-3, phi_l1 high ph 4-7, phi_r high ph 0-1, sample only at ph 7. col_idx steps 0..7 and row_idx steps 0..3.
- integ_cycles=0 -> behaves as 1, first phi_p rises 1 cycle after busy rises, total busy = 273 cycles.
- start reasserted mid-frame, and start held high continuously -> second frame starts only after return to IDLE (cycle after done), no frame overlap.
- abort in the 3rd row's HSHIFT -> next edge busy=0, phi_l2=1, others 0, no done pulse. A following start runs a full normal frame.
- rst_n asserted mid-PXFER (async, between edges) -> outputs reach reset values without a clock edge. After release and start, the frame runs normally. Invariants are asserted throughout all tests.

Source files
------------

// File: rtl/ccd_readout_sequencer.sv
// Frame sequencer for the CCD clock drivers: integration, then per row one
// parallel transfer followed by an N_COLS-pixel horizontal shift with ADC strobes.
module ccd_readout_sequencer #(
  parameter int unsigned N_ROWS  = 4,
  parameter int unsigned N_COLS  = 8,
  parameter int unsigned HALF    = 4,
  parameter int unsigned P_WIDTH = 4,
  parameter int unsigned RST_W   = 2,
  localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int unsigned CW = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   integ_cycles,
  output logic          busy,
  output logic          done,
  output logic          phi_p,
  output logic          phi_l1,
  output logic          phi_l2,
  output logic          phi_r,
  output logic          sample,
  output logic [RW-1:0] row_idx,
  output logic [CW-1:0] col_idx
);

  localparam int unsigned PW = $clog2(2 * HALF);

  typedef enum logic [2:0] {IDLE, INTEG, PXFER, HSHIFT, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   integ_len_q, integ_len_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  logic busy_d, done_d, phi_p_d, phi_l1_d, phi_l2_d, phi_r_d, sample_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      integ_len_q <= '0;
      ph_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      phi_p       <= 1'b0;
      phi_l1      <= 1'b0;
      phi_l2      <= 1'b1;
      phi_r       <= 1'b0;
      sample      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      integ_len_q <= integ_len_d;
      ph_q        <= ph_d;
      row_q       <= row_d;
      col_q       <= col_d;
      busy        <= busy_d;
      done        <= done_d;
      phi_p       <= phi_p_d;
      phi_l1      <= phi_l1_d;
      phi_l2      <= phi_l2_d;
      phi_r       <= phi_r_d;
      sample      <= sample_d;
    end
  end

  assign row_idx = row_q;
  assign col_idx = col_q;

  // Outputs are decoded from the next state/phase so they register on the same edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    integ_len_d = integ_len_q;
    ph_d        = ph_q;
    row_d       = row_q;
    col_d       = col_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          integ_len_d = (integ_cycles == 16'd0) ? 16'd1 : integ_cycles;
          cnt_d       = '0;
          state_d     = INTEG;
        end
      end
      INTEG: begin
        if (cnt_q == integ_len_q - 16'd1) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = PXFER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PXFER: begin
        if (cnt_q == 16'(P_WIDTH - 1)) begin
          cnt_d   = '0;
          ph_d    = '0;
          col_d   = '0;
          state_d = HSHIFT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HSHIFT: begin
        if (ph_q == PW'(2 * HALF - 1)) begin
          ph_d = '0;
          if (col_q == CW'(N_COLS - 1)) begin
            col_d = '0;
            if (row_q == RW'(N_ROWS - 1)) begin
              state_d = DONE;
            end else begin
              row_d   = row_q + RW'(1);
              cnt_d   = '0;
              state_d = PXFER;
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          ph_d = ph_q + PW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      cnt_d       = '0;
      integ_len_d = '0;
      ph_d        = '0;
      row_d       = '0;
      col_d       = '0;
    end

    busy_d   = (state_d == INTEG) || (state_d == PXFER) || (state_d == HSHIFT);
    done_d   = (state_d == DONE);
    phi_p_d  = (state_d == PXFER);
    phi_l1_d = 1'b0;
    phi_l2_d = 1'b1;
    phi_r_d  = 1'b0;
    sample_d = 1'b0;
    if (state_d == HSHIFT) begin
      phi_l2_d = (ph_d < PW'(HALF));
      phi_l1_d = !(ph_d < PW'(HALF));
      phi_r_d  = (ph_d < PW'(RST_W));
      sample_d = (ph_d == PW'(2 * HALF - 1));
    end
  end

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// Randomized scoreboard bench for ccd_readout_sequencer against a frame-timing model.
module tb_ccd_readout_sequencer;

  localparam int unsigned N_ROWS  = 4;
  localparam int unsigned N_COLS  = 8;
  localparam int unsigned HALF    = 4;
  localparam int unsigned P_WIDTH = 4;
  localparam int unsigned RST_W   = 2;
  localparam int unsigned RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int unsigned PER = P_WIDTH + 2 * HALF * N_COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   integ_cycles = '0;
  logic          busy, done, phi_p, phi_l1, phi_l2, phi_r, sample;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;

  ccd_readout_sequencer #(
    .N_ROWS(N_ROWS), .N_COLS(N_COLS), .HALF(HALF), .P_WIDTH(P_WIDTH), .RST_W(RST_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .integ_cycles(integ_cycles),
    .busy(busy), .done(done), .phi_p(phi_p), .phi_l1(phi_l1), .phi_l2(phi_l2),
    .phi_r(phi_r), .sample(sample), .row_idx(row_idx), .col_idx(col_idx)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one frame window plus a queue of expected strobe events.
  typedef struct {
    bit          is_done;
    int unsigned cyc;
    int unsigned row;
    int unsigned col;
  } ev_t;
  ev_t sbq[$];

  typedef struct packed {
    logic          busy;
    logic          p;
    logic          l1;
    logic          l2;
    logic          r;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } lv_t;

  bit          fr_valid = 1'b0;
  bit          fr_has_done = 1'b0;
  int unsigned fr_t0 = 0;
  int unsigned fr_il = 0;
  int unsigned fr_stop = 0;
  int unsigned next_ok = 0;
  int          m_done_exp = 0;

  function automatic lv_t model_levels(input int unsigned c, output bit skip);
    lv_t v;
    int unsigned o, w, pix, ph;
    v = '0;
    v.l2 = 1'b1;
    skip = fr_valid && fr_has_done && (c == fr_stop);
    if (fr_valid && c >= fr_t0 && c < fr_stop) begin
      v.busy = 1'b1;
      o = c - fr_t0;
      if (o >= fr_il) begin
        o = o - fr_il;
        v.row = RW'(o / PER);
        w = o % PER;
        if (w < P_WIDTH) begin
          v.p = 1'b1;
        end else begin
          pix   = w - P_WIDTH;
          v.col = CW'(pix / (2 * HALF));
          ph    = pix % (2 * HALF);
          v.l2  = (ph < HALF);
          v.l1  = (ph >= HALF);
          v.r   = (ph < RST_W);
        end
      end
    end
    return v;
  endfunction

  task automatic flush_from(input int unsigned k);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].cyc >= k) sbq.delete(i);
  endtask

  // Drive one cycle of inputs (sampled at the next edge) and advance the model.
  task automatic step(input bit s, input bit a, input logic [15:0] iv);
    int unsigned k;
    k = cyc + 1;
    start = s;
    abort = a;
    integ_cycles = iv;
    if (a) begin
      if (fr_valid && (k - 1) >= fr_t0 && (k - 1) < fr_stop) begin
        fr_stop = k;
        if (fr_has_done) m_done_exp--;
        fr_has_done = 1'b0;
        flush_from(k);
        next_ok = k + 1;
      end
    end else if (s && rst_n && k >= next_ok) begin
      fr_valid    = 1'b1;
      fr_has_done = 1'b1;
      fr_t0       = k;
      fr_il       = (iv == 16'd0) ? 1 : int'(iv);
      fr_stop     = k + fr_il + N_ROWS * PER;
      next_ok     = fr_stop + 2;
      m_done_exp++;
      for (int unsigned r = 0; r < N_ROWS; r++)
        for (int unsigned c = 0; c < N_COLS; c++)
          sbq.push_back('{1'b0, k + fr_il + r * PER + P_WIDTH + c * 2 * HALF + 2 * HALF - 1, r, c});
      sbq.push_back('{1'b1, fr_stop, 0, 0});
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_frame(input logic [15:0] iv);
    step(1'b1, 1'b0, iv);
    while (cyc + 1 < next_ok) step(1'b0, 1'b0, iv);
  endtask

  int busy_cnt = 0, samp_cnt = 0, done_cnt = 0, pp_cnt = 0;
  logic pp_prev = 1'b0;

  task automatic clear_counts();
    busy_cnt = 0; samp_cnt = 0; done_cnt = 0; pp_cnt = 0; m_done_exp = 0;
  endtask

  // Monitor: per-cycle level check against the model, invariants, and event scoreboard.
  lv_t m_exp, m_act;
  bit  m_skip;
  ev_t m_ev;
  always @(negedge clk) begin
    m_exp = model_levels(cyc, m_skip);
    m_act = {busy, phi_p, phi_l1, phi_l2, phi_r, row_idx, col_idx};
    if (m_skip) begin
      m_act.row = m_exp.row;
      m_act.col = m_exp.col;
    end
    chk($sformatf("levels@%0d", cyc), 64'(m_act), 64'(m_exp));
    chk($sformatf("invariant@%0d", cyc),
        64'((phi_p && (phi_l1 || phi_r || sample)) || (phi_l1 && phi_l2) ||
            (rst_n && !phi_l1 && !phi_l2)), 64'(0));

    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      chk($sformatf("event_seen@%0d", sbq[0].cyc), 64'(cyc), 64'(sbq[0].cyc));
      void'(sbq.pop_front());
    end
    if (sample || done) begin
      if (sbq.size() == 0) begin
        chk($sformatf("unexpected_event@%0d", cyc), 64'({done, sample}), 64'(0));
      end else begin
        m_ev = sbq.pop_front();
        chk($sformatf("event@%0d", cyc),
            64'({cyc, done, sample, row_idx, col_idx}),
            64'({m_ev.cyc, m_ev.is_done, !m_ev.is_done,
                 m_ev.is_done ? row_idx : RW'(m_ev.row),
                 m_ev.is_done ? col_idx : CW'(m_ev.col)}));
      end
    end

    if (busy) busy_cnt++;
    if (sample) samp_cnt++;
    if (done) done_cnt++;
    if (phi_p && !pp_prev) pp_cnt++;
    pp_prev = phi_p;
  end

  logic [63:0] rst_vec;
  assign rst_vec = 64'({busy, done, phi_p, phi_l1, phi_l2, phi_r, sample, row_idx, col_idx});
  localparam logic [63:0] RST_EXP = 64'({7'b0000100, RW'(0), CW'(0)});

  initial begin
    int unsigned target;
    logic [15:0] iv;
    bit hold;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", rst_vec, RST_EXP);
    rst_n = 1'b1;
    next_ok = 0;
    step(1'b0, 1'b1, 16'd0);
    step(1'b0, 1'b0, 16'd0);

    // Default frame.
    clear_counts();
    run_frame(16'd10);
    chk("busy_cycles_i10", 64'(busy_cnt), 64'(282));
    chk("sample_count", 64'(samp_cnt), 64'(N_ROWS * N_COLS));
    chk("phi_p_pulses", 64'(pp_cnt), 64'(N_ROWS));
    chk("done_count", 64'(done_cnt), 64'(1));

    // Zero integration length behaves as one cycle.
    clear_counts();
    run_frame(16'd0);
    chk("busy_cycles_i0", 64'(busy_cnt), 64'(273));

    // start pulses mid-frame are ignored.
    clear_counts();
    step(1'b1, 1'b0, 16'd7);
    while (cyc + 1 < next_ok) step($urandom_range(0, 5) == 0, 1'b0, 16'($urandom));
    chk("done_count_midstart", 64'(done_cnt), 64'(m_done_exp));

    // start held high continuously: frames back to back, never overlapping.
    clear_counts();
    for (int i = 0; i < 620; i++) step(1'b1, 1'b0, 16'd5);
    while (cyc + 1 < next_ok) step(1'b0, 1'b0, 16'd5);
    chk("done_count_held", 64'(done_cnt), 64'(m_done_exp));

    // Abort in the third row's horizontal shift.
    clear_counts();
    step(1'b1, 1'b0, 16'd10);
    target = fr_t0 + fr_il + 2 * PER + P_WIDTH + 20;
    while (cyc + 1 < target) step(1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 16'd0);
    chk("busy_after_abort", 64'(busy), 64'(0));
    repeat (4) step(1'b0, 1'b0, 16'd0);
    chk("done_after_abort", 64'(done_cnt), 64'(0));
    clear_counts();
    run_frame(16'd10);
    chk("busy_cycles_post_abort", 64'(busy_cnt), 64'(282));

    // Asynchronous reset in the second row's parallel transfer.
    step(1'b1, 1'b0, 16'd3);
    target = fr_t0 + fr_il + PER + 1;
    while (cyc < target) step(1'b0, 1'b0, 16'd0);
    chk("phi_p_before_reset", 64'(phi_p), 64'(1));
    rst_n = 1'b0;
    fr_stop = cyc;
    fr_has_done = 1'b0;
    flush_from(cyc);
    next_ok = 0;
    #1;
    chk("async_reset_outputs", rst_vec, RST_EXP);
    repeat (3) step(1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;
    clear_counts();
    run_frame(16'd10);
    chk("busy_cycles_post_reset", 64'(busy_cnt), 64'(282));
    chk("done_count_post_reset", 64'(done_cnt), 64'(1));

    // Randomized traffic with occasional aborts.
    for (int it = 0; it < 10; it++) begin
      iv = 16'($urandom_range(0, 25));
      hold = ($urandom_range(0, 1) == 1);
      clear_counts();
      for (int j = 0; j < 450; j++)
        step(hold ? 1'b1 : ($urandom_range(0, 3) == 0), ($urandom_range(0, 249) == 0), iv);
      while (cyc + 1 < next_ok) step(1'b0, 1'b0, iv);
      chk($sformatf("done_count_rand%0d", it), 64'(done_cnt), 64'(m_done_exp));
    end

    repeat (4) step(1'b0, 1'b0, 16'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
